// File: rtl/rns_digit_count_sched.sv
// rns_digit_count_sched: one shared two-stage residue increment pipeline,
// time-shared round-robin among NUM_CH single-digit modular counters.
// A channel sitting in stage 1 is masked from arbitration, so a channel
// is never re-granted before its previous increment has been written back.
module rns_digit_count_sched #(
    parameter int DATA_WIDTH = 18,
    parameter int MODULUS    = 177147,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     inc_req,
    output logic [NUM_CH-1:0]     inc_gnt,
    input  logic [NUM_CH-1:0]     clr,
    input  logic [CH_W-1:0]       rd_sel,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [NUM_CH-1:0]     wrap_pulse,
    output logic                  busy
);

    localparam logic [DATA_WIDTH:0] MOD_VAL = (DATA_WIDTH + 1)'(MODULUS);
    localparam logic [DATA_WIDTH:0] ONE     = (DATA_WIDTH + 1)'(1);
    localparam logic [CH_W-1:0]     LAST_CH = CH_W'(NUM_CH - 1);

    logic [DATA_WIDTH-1:0] count [NUM_CH];
    logic [CH_W-1:0]       ptr;
    logic                  s1_valid;
    logic [CH_W-1:0]       s1_tag;
    logic [DATA_WIDTH:0]   s1_sum;

    logic [NUM_CH-1:0]     s1_mask;
    logic [NUM_CH-1:0]     eligible;
    logic                  gnt_found;
    logic [CH_W-1:0]       gnt_idx;
    logic [CH_W-1:0]       cand;
    logic                  wb_wrap;

    // Eligible channels: requesting, not being cleared, not already in flight.
    always_comb begin
        s1_mask  = s1_valid ? (NUM_CH'(1) << s1_tag) : '0;
        eligible = inc_req & ~clr & ~s1_mask;
    end

    // Round-robin search over eligible channels starting at the pointer.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = CH_W'((int'(ptr) + k) % NUM_CH);
            if (!gnt_found && eligible[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Grant is one-hot and forced low while reset is asserted.
    always_comb begin
        inc_gnt = '0;
        if (rst_n && gnt_found) begin
            inc_gnt = NUM_CH'(1) << gnt_idx;
        end
    end

    // Stage 1 captures the widened sum and the channel tag; pointer advances past the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_tag   <= '0;
            s1_sum   <= '0;
            ptr      <= '0;
        end else begin
            s1_valid <= gnt_found;
            if (gnt_found) begin
                s1_tag <= gnt_idx;
                s1_sum <= {1'b0, count[gnt_idx]} + ONE;
                ptr    <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Counts never exceed MODULUS-1, so the sum can only reach MODULUS exactly.
    assign wb_wrap = (s1_sum == MOD_VAL);

    // Writeback folds the wrap to zero; a clear on the same channel wins and kills the writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count[i] <= '0;
            end
            wrap_pulse <= '0;
        end else begin
            wrap_pulse <= '0;
            if (s1_valid && !clr[s1_tag]) begin
                count[s1_tag]      <= wb_wrap ? '0 : s1_sum[DATA_WIDTH-1:0];
                wrap_pulse[s1_tag] <= wb_wrap;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr[i]) begin
                    count[i] <= '0;
                end
            end
        end
    end

    // Readback shows committed counts only; out-of-range selects read zero.
    always_comb begin
        rd_data = '0;
        if (int'(rd_sel) < NUM_CH) begin
            rd_data = count[rd_sel];
        end
    end

    assign busy = s1_valid;

endmodule

// File: tb/tb_rns_digit_count_sched.sv
// tb_rns_digit_count_sched: directed checks of arbitration, pipeline latency,
// clear priority, wrap and mid-operation reset for rns_digit_count_sched.
module tb_rns_digit_count_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  inc_req;
    logic [3:0]  clr;
    logic [1:0]  rd_sel;
    logic [3:0]  inc_gnt;
    logic [17:0] rd_data;
    logic [3:0]  wrap_pulse;
    logic        busy;

    logic [3:0]  inc_req5;
    logic [3:0]  clr5;
    logic [1:0]  rd_sel5;
    logic [3:0]  inc_gnt5;
    logic [2:0]  rd_data5;
    logic [3:0]  wrap_pulse5;
    logic        busy5;

    int checks = 0;
    int errors = 0;

    rns_digit_count_sched #(
        .DATA_WIDTH(18),
        .MODULUS(177147),
        .NUM_CH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .inc_req(inc_req),
        .inc_gnt(inc_gnt),
        .clr(clr),
        .rd_sel(rd_sel),
        .rd_data(rd_data),
        .wrap_pulse(wrap_pulse),
        .busy(busy)
    );

    rns_digit_count_sched #(
        .DATA_WIDTH(3),
        .MODULUS(5),
        .NUM_CH(4)
    ) dut5 (
        .clk(clk),
        .rst_n(rst_n),
        .inc_req(inc_req5),
        .inc_gnt(inc_gnt5),
        .clr(clr5),
        .rd_sel(rd_sel5),
        .rd_data(rd_data5),
        .wrap_pulse(wrap_pulse5),
        .busy(busy5)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive the main instance's inputs mid-cycle and let combinational outputs settle.
    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] clear, input logic [1:0] sel);
        @(negedge clk);
        inc_req = req;
        clr     = clear;
        rd_sel  = sel;
        #1;
    endtask

    task automatic applyStimulus5(input logic [3:0] req);
        @(negedge clk);
        inc_req5 = req;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n   = 1'b0;
        inc_req = '0;
        clr     = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        inc_req  = 4'b1111;
        clr      = '0;
        rd_sel   = '0;
        inc_req5 = '0;
        clr5     = '0;
        rd_sel5  = 2'd2;
        #1;
        checkOutput("reset_gnt", 32'(inc_gnt), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_wrap", 32'(wrap_pulse), 32'h0);
        checkOutput("reset_rd", 32'(rd_data), 32'h0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        inc_req = '0;
        #1;

        // Single channel: granted every second cycle, value visible two cycles later.
        for (int c = 0; c < 6; c++) begin
            applyStimulus(4'b0001, 4'b0000, 2'd0);
            checkOutput($sformatf("t1_gnt_c%0d", c), 32'(inc_gnt), (c % 2 == 0) ? 32'h1 : 32'h0);
            checkOutput($sformatf("t1_busy_c%0d", c), 32'(busy), (c % 2 == 1) ? 32'h1 : 32'h0);
            checkOutput($sformatf("t1_rd_c%0d", c), 32'(rd_data), 32'(c / 2));
        end
        applyStimulus(4'b0000, 4'b0000, 2'd0);
        checkOutput("t1_rd_c6", 32'(rd_data), 32'd3);
        checkOutput("t1_busy_c6", 32'(busy), 32'h0);

        // All channels requesting: strict rotation, one grant per cycle.
        doReset();
        for (int c = 0; c < 8; c++) begin
            applyStimulus(4'b1111, 4'b0000, 2'd0);
            checkOutput($sformatf("t2_gnt_c%0d", c), 32'(inc_gnt), 32'(1 << (c % 4)));
        end
        applyStimulus(4'b0000, 4'b0000, 2'd0);
        checkOutput("t2_busy_c8", 32'(busy), 32'h1);
        applyStimulus(4'b0000, 4'b0000, 2'd0);
        checkOutput("t2_busy_c9", 32'(busy), 32'h0);
        applyStimulus(4'b0000, 4'b0000, 2'd0);
        for (int ch = 0; ch < 4; ch++) begin
            rd_sel = 2'(ch);
            #1;
            checkOutput($sformatf("t2_count_ch%0d", ch), 32'(rd_data), 32'd2);
        end

        // Clear while channel 1 is in flight: writeback dropped, request masked.
        applyStimulus(4'b0010, 4'b0000, 2'd1);
        checkOutput("t4_gnt_T", 32'(inc_gnt), 32'h2);
        applyStimulus(4'b0010, 4'b0010, 2'd1);
        checkOutput("t4_gnt_T1", 32'(inc_gnt), 32'h0);
        checkOutput("t4_busy_T1", 32'(busy), 32'h1);
        applyStimulus(4'b0000, 4'b0000, 2'd1);
        checkOutput("t4_rd_T2", 32'(rd_data), 32'h0);
        checkOutput("t4_wrap_T2", 32'(wrap_pulse), 32'h0);
        rd_sel = 2'd0;
        #1;
        checkOutput("t4_ch0_kept", 32'(rd_data), 32'd2);

        // Pointer sits at 2 after the grant to channel 1.
        applyStimulus(4'b0110, 4'b0000, 2'd0);
        checkOutput("t5_gnt_a0", 32'(inc_gnt), 32'h4);
        applyStimulus(4'b0110, 4'b0000, 2'd0);
        checkOutput("t5_gnt_a1", 32'(inc_gnt), 32'h2);
        applyStimulus(4'b0110, 4'b0000, 2'd0);
        checkOutput("t5_gnt_a2", 32'(inc_gnt), 32'h4);
        applyStimulus(4'b1000, 4'b0000, 2'd0);
        checkOutput("t5_gnt_a3", 32'(inc_gnt), 32'h8);
        applyStimulus(4'b1000, 4'b0000, 2'd0);
        checkOutput("t5_gnt_a4", 32'(inc_gnt), 32'h0);
        applyStimulus(4'b1000, 4'b0000, 2'd0);
        checkOutput("t5_gnt_a5", 32'(inc_gnt), 32'h8);
        applyStimulus(4'b0000, 4'b0000, 2'd0);
        checkOutput("t5_gnt_a6", 32'(inc_gnt), 32'h0);
        applyStimulus(4'b0000, 4'b0000, 2'd3);
        checkOutput("t5_count_ch3", 32'(rd_data), 32'd4);
        rd_sel = 2'd2;
        #1;
        checkOutput("t5_count_ch2", 32'(rd_data), 32'd4);
        rd_sel = 2'd1;
        #1;
        checkOutput("t5_count_ch1", 32'(rd_data), 32'd1);

        // Reset while channels 0 and 3 are in flight.
        applyStimulus(4'b1001, 4'b0000, 2'd0);
        checkOutput("t6_gnt_b0", 32'(inc_gnt), 32'h1);
        applyStimulus(4'b1001, 4'b0000, 2'd0);
        checkOutput("t6_gnt_b1", 32'(inc_gnt), 32'h8);
        checkOutput("t6_busy_b1", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_gnt", 32'(inc_gnt), 32'h0);
        checkOutput("t6_rst_busy", 32'(busy), 32'h0);
        checkOutput("t6_rst_wrap", 32'(wrap_pulse), 32'h0);
        checkOutput("t6_rst_rd0", 32'(rd_data), 32'h0);
        rd_sel = 2'd3;
        #1;
        checkOutput("t6_rst_rd3", 32'(rd_data), 32'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        inc_req = 4'b1001;
        #1;
        checkOutput("t6_rel_gnt", 32'(inc_gnt), 32'h1);
        checkOutput("t6_rel_busy", 32'(busy), 32'h0);
        checkOutput("t6_rel_rd3", 32'(rd_data), 32'h0);
        applyStimulus(4'b1001, 4'b0000, 2'd0);
        checkOutput("t6_gnt_r1", 32'(inc_gnt), 32'h8);
        applyStimulus(4'b0000, 4'b0000, 2'd0);
        checkOutput("t6_rd0_r2", 32'(rd_data), 32'd1);
        checkOutput("t6_wrap_r2", 32'(wrap_pulse), 32'h0);
        applyStimulus(4'b0000, 4'b0000, 2'd3);
        checkOutput("t6_rd3_r3", 32'(rd_data), 32'd1);

        // Modulus-5 instance: channel 2 counts 1,2,3,4,0 and wraps once.
        for (int g = 1; g <= 5; g++) begin
            applyStimulus5(4'b0100);
            checkOutput($sformatf("t3_gnt_g%0d", g), 32'(inc_gnt5), 32'h4);
            checkOutput($sformatf("t3_rd_before_g%0d", g), 32'(rd_data5), 32'(g - 1));
            checkOutput($sformatf("t3_wrap_before_g%0d", g), 32'(wrap_pulse5), 32'h0);
            applyStimulus5((g == 5) ? 4'b0000 : 4'b0100);
            checkOutput($sformatf("t3_gap_g%0d", g), 32'(inc_gnt5), 32'h0);
            checkOutput($sformatf("t3_gap_wrap_g%0d", g), 32'(wrap_pulse5), 32'h0);
        end
        applyStimulus5(4'b0000);
        checkOutput("t3_rd_final", 32'(rd_data5), 32'h0);
        checkOutput("t3_wrap_final", 32'(wrap_pulse5), 32'h4);
        applyStimulus5(4'b0000);
        checkOutput("t3_wrap_after", 32'(wrap_pulse5), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
